// File: rtl/butterfly_pkg.sv
// -----------------------------------------------------------------------------
// butterfly_pkg
// Shared definitions for the ButterFly core front end: RV32 opcode / funct
// constants, ALU / branch / mul-div / system enumerations, the decoded
// instruction bundle passed from decode to execute, and small helpers that
// extract immediates and map funct3 onto ALU and branch operations.
// Ports: none (package).
// -----------------------------------------------------------------------------
package butterfly_pkg;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL      = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
    localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
    localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPCODE_OP       = 7'b0110011;
    localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPCODE_SYSTEM   = 7'b1110011;

    // ALU funct3
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // Branch funct3
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // funct7 groups
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // System instruction bodies (instr[31:7])
    localparam logic [24:0] SYS_BODY_ECALL  = 25'h0000000;
    localparam logic [24:0] SYS_BODY_EBREAK = 25'h0002000;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_e;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_EQ   = 3'd1,
        BR_NE   = 3'd2,
        BR_LT   = 3'd3,
        BR_GE   = 3'd4,
        BR_LTU  = 3'd5,
        BR_GEU  = 3'd6
    } branch_type_e;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        SYS_NONE   = 2'b00,
        SYS_ECALL  = 2'b01,
        SYS_EBREAK = 2'b10
    } sys_e;

    // Everything execute needs except the pc. All-zero is the idle bundle.
    typedef struct packed {
        logic [4:0]   rs1_addr;
        logic [4:0]   rs2_addr;
        logic [4:0]   rd_addr;
        logic [31:0]  imm;
        logic         reg_write;
        logic         mem_read;
        logic         mem_write;
        logic         branch;
        logic         jump;
        alu_op_e      alu_op;
        branch_type_e branch_type;
        logic         md_en;
        md_op_e       md_op;
        logic [2:0]   mem_size;
        sys_e         sys;
        logic         illegal;
    } decoded_instr_t;

    function automatic logic [31:0] imm_i(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[31:25], instr[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] instr);
        return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] instr);
        return {instr[31:12], 12'h000};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] instr);
        return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

    // alt selects SUB / SRA for funct3 000 / 101.
    function automatic alu_op_e alu_op_from_f3(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:     op = ALU_SLL;
            F3_SLT:     op = ALU_SLT;
            F3_SLTU:    op = ALU_SLTU;
            F3_XOR:     op = ALU_XOR;
            F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:      op = ALU_OR;
            F3_AND:     op = ALU_AND;
            default:    op = ALU_ADD;
        endcase
        return op;
    endfunction

    // BR_NONE marks the two reserved branch funct3 codes.
    function automatic branch_type_e branch_type_from_f3(input logic [2:0] f3);
        branch_type_e bt;
        case (f3)
            F3_BEQ:  bt = BR_EQ;
            F3_BNE:  bt = BR_NE;
            F3_BLT:  bt = BR_LT;
            F3_BGE:  bt = BR_GE;
            F3_BLTU: bt = BR_LTU;
            F3_BGEU: bt = BR_GEU;
            default: bt = BR_NONE;
        endcase
        return bt;
    endfunction

endpackage

// File: rtl/instr_decode_comb.sv
// -----------------------------------------------------------------------------
// instr_decode_comb
// Purely combinational RV32I(+M) decoder: instruction word -> decoded bundle.
// Illegal and NOP encodings leave every control, the immediate and all
// operation selects at zero; only the register index fields and the illegal
// flag are populated for them.
// Ports:
//   i_instr  in   32  instruction word
//   o_dec    out  decoded_instr_t  decoded bundle (reg_write not yet x0-masked)
// -----------------------------------------------------------------------------
module instr_decode_comb
    import butterfly_pkg::*;
#(
    parameter bit ENABLE_M = 1'b1
) (
    input  logic [31:0]    i_instr,
    output decoded_instr_t o_dec
);

    logic [6:0]   w_opcode;
    logic [2:0]   w_funct3;
    logic [6:0]   w_funct7;
    branch_type_e w_bt;
    decoded_instr_t w_dec;

    assign w_opcode = i_instr[6:0];
    assign w_funct3 = i_instr[14:12];
    assign w_funct7 = i_instr[31:25];
    assign w_bt     = branch_type_from_f3(w_funct3);
    assign o_dec    = w_dec;

    // Main decode: start from the idle bundle and fill in only legal fields.
    always_comb begin
        w_dec          = '0;
        w_dec.rs1_addr = i_instr[19:15];
        w_dec.rs2_addr = i_instr[24:20];
        w_dec.rd_addr  = i_instr[11:7];
        case (w_opcode)
            OPCODE_LUI: begin
                w_dec.imm       = imm_u(i_instr);
                w_dec.reg_write = 1'b1;
                w_dec.alu_op    = ALU_PASS_B;
            end
            OPCODE_AUIPC: begin
                w_dec.imm       = imm_u(i_instr);
                w_dec.reg_write = 1'b1;
                w_dec.alu_op    = ALU_ADD;
            end
            OPCODE_JAL: begin
                w_dec.imm       = imm_j(i_instr);
                w_dec.reg_write = 1'b1;
                w_dec.jump      = 1'b1;
            end
            OPCODE_JALR: begin
                if (w_funct3 == 3'b000) begin
                    w_dec.imm       = imm_i(i_instr);
                    w_dec.reg_write = 1'b1;
                    w_dec.jump      = 1'b1;
                end else begin
                    w_dec.illegal = 1'b1;
                end
            end
            OPCODE_BRANCH: begin
                if (w_bt != BR_NONE) begin
                    w_dec.imm         = imm_b(i_instr);
                    w_dec.branch      = 1'b1;
                    w_dec.branch_type = w_bt;
                end else begin
                    w_dec.illegal = 1'b1;
                end
            end
            OPCODE_LOAD: begin
                if (w_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) begin
                    w_dec.imm       = imm_i(i_instr);
                    w_dec.mem_read  = 1'b1;
                    w_dec.reg_write = 1'b1;
                    w_dec.mem_size  = w_funct3;
                end else begin
                    w_dec.illegal = 1'b1;
                end
            end
            OPCODE_STORE: begin
                if (w_funct3 <= 3'b010) begin
                    w_dec.imm       = imm_s(i_instr);
                    w_dec.mem_write = 1'b1;
                    w_dec.mem_size  = w_funct3;
                end else begin
                    w_dec.illegal = 1'b1;
                end
            end
            OPCODE_OP_IMM: begin
                // Only the shift forms constrain funct7 (it overlays imm[11:5]).
                if ((w_funct3 != F3_SLL && w_funct3 != F3_SRL_SRA) ||
                    (w_funct7 == F7_BASE) ||
                    (w_funct3 == F3_SRL_SRA && w_funct7 == F7_ALT)) begin
                    w_dec.imm       = imm_i(i_instr);
                    w_dec.reg_write = 1'b1;
                    w_dec.alu_op    = alu_op_from_f3(w_funct3,
                                        (w_funct3 == F3_SRL_SRA) && (w_funct7 == F7_ALT));
                end else begin
                    w_dec.illegal = 1'b1;
                end
            end
            OPCODE_OP: begin
                if (w_funct7 == F7_BASE) begin
                    w_dec.reg_write = 1'b1;
                    w_dec.alu_op    = alu_op_from_f3(w_funct3, 1'b0);
                end else if (w_funct7 == F7_ALT &&
                             (w_funct3 == F3_ADD_SUB || w_funct3 == F3_SRL_SRA)) begin
                    w_dec.reg_write = 1'b1;
                    w_dec.alu_op    = alu_op_from_f3(w_funct3, 1'b1);
                end else if (ENABLE_M && w_funct7 == F7_MULDIV) begin
                    // alu_op stays ALU_ADD; execute routes these to the mul/div unit.
                    w_dec.reg_write = 1'b1;
                    w_dec.md_en     = 1'b1;
                    w_dec.md_op     = md_op_e'(w_funct3);
                end else begin
                    w_dec.illegal = 1'b1;
                end
            end
            OPCODE_MISC_MEM: begin
                // FENCE family retires as a NOP in this in-order core.
                w_dec.illegal = 1'b0;
            end
            OPCODE_SYSTEM: begin
                if (i_instr[31:7] == SYS_BODY_ECALL) begin
                    w_dec.sys = SYS_ECALL;
                end else if (i_instr[31:7] == SYS_BODY_EBREAK) begin
                    w_dec.sys = SYS_EBREAK;
                end else begin
                    w_dec.illegal = 1'b1;
                end
            end
            default: begin
                w_dec.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
// Registered decode stage between fetch and execute. The raw instruction is
// decoded combinationally on the way in; a 2-entry buffer (output register +
// skid register) holds decoded bundles so in_ready_o depends only on state.
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   flush_i                  drop every buffered bundle and this cycle's input
//   in_valid_i/in_ready_o    upstream handshake; instr_i, pc_i payload
//   out_valid_o/out_ready_i  downstream handshake
//   pc_o, rs1/rs2/rd_addr_o, imm_o, control and select fields  decoded bundle
// -----------------------------------------------------------------------------
module decode_stage
    import butterfly_pkg::*;
#(
    parameter bit ENABLE_M               = 1'b1,
    parameter int PC_W                   = 32,
    parameter bit ZERO_RD_WRITE_SUPPRESS = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     instr_i,
    input  logic [PC_W-1:0] pc_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [PC_W-1:0] pc_o,
    output logic [4:0]      rs1_addr_o,
    output logic [4:0]      rs2_addr_o,
    output logic [4:0]      rd_addr_o,
    output logic [31:0]     imm_o,
    output logic            reg_write_o,
    output logic            mem_read_o,
    output logic            mem_write_o,
    output logic            branch_o,
    output logic            jump_o,
    output logic [3:0]      alu_op_o,
    output logic [2:0]      branch_type_o,
    output logic            md_en_o,
    output logic [2:0]      md_op_o,
    output logic [2:0]      mem_size_o,
    output logic [1:0]      sys_o,
    output logic            illegal_o
);

    decoded_instr_t  w_dec;
    decoded_instr_t  w_dec_fix;
    logic            w_accept;
    logic            w_out_free;

    decoded_instr_t  r_out;
    decoded_instr_t  r_skid;
    logic [PC_W-1:0] r_out_pc;
    logic [PC_W-1:0] r_skid_pc;
    logic            r_out_valid;
    logic            r_skid_valid;

    instr_decode_comb #(
        .ENABLE_M (ENABLE_M)
    ) u_decode (
        .i_instr (instr_i),
        .o_dec   (w_dec)
    );

    // Writes to x0 are dropped here so execute never has to special-case them.
    always_comb begin
        w_dec_fix = w_dec;
        if (ZERO_RD_WRITE_SUPPRESS && (w_dec.rd_addr == 5'd0)) begin
            w_dec_fix.reg_write = 1'b0;
        end else begin
            w_dec_fix.reg_write = w_dec.reg_write;
        end
    end

    // Ready only reflects skid occupancy, never out_ready_i.
    assign in_ready_o = !r_skid_valid;
    assign w_accept   = in_valid_i && !r_skid_valid && !flush_i;
    assign w_out_free = !r_out_valid || out_ready_i;

    // Two-entry buffer: output register refills from skid first, else from input.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_out        <= '0;
            r_skid       <= '0;
            r_out_pc     <= '0;
            r_skid_pc    <= '0;
        end else if (flush_i) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_out_free) begin
            if (r_skid_valid) begin
                r_out        <= r_skid;
                r_out_pc     <= r_skid_pc;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_out        <= w_dec_fix;
                r_out_pc     <= pc_i;
                r_out_valid  <= 1'b1;
            end else begin
                r_out_valid  <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid       <= w_dec_fix;
            r_skid_pc    <= pc_i;
            r_skid_valid <= 1'b1;
        end else begin
            r_skid_valid <= r_skid_valid;
        end
    end

    assign out_valid_o   = r_out_valid;
    assign pc_o          = r_out_pc;
    assign rs1_addr_o    = r_out.rs1_addr;
    assign rs2_addr_o    = r_out.rs2_addr;
    assign rd_addr_o     = r_out.rd_addr;
    assign imm_o         = r_out.imm;
    assign reg_write_o   = r_out.reg_write;
    assign mem_read_o    = r_out.mem_read;
    assign mem_write_o   = r_out.mem_write;
    assign branch_o      = r_out.branch;
    assign jump_o        = r_out.jump;
    assign alu_op_o      = r_out.alu_op;
    assign branch_type_o = r_out.branch_type;
    assign md_en_o       = r_out.md_en;
    assign md_op_o       = r_out.md_op;
    assign mem_size_o    = r_out.mem_size;
    assign sys_o         = r_out.sys;
    assign illegal_o     = r_out.illegal;

endmodule
